vpu_timing_cntr_bank: RTL

Bank of NUM_CH independent saturating down-counters that enforce timing constraints (e.g., per-bank or per-command minimum spacing) for the VPU command scheduler.
Each channel can be loaded by the address decoder in overwrite or keep-longest (max) mode. Channels can be frozen globally and flushed.
Each channel reports registered and one-cycle-early ready flags, plus an expiry pulse. The bank sits between the address decoder and the issue arbiter.

---
 rtl/vpu_timing_pkg.sv | 16 +
 rtl/vpu_timing_cntr_bank_if.sv | 58 +++++
 rtl/vpu_timing_cntr_ch.sv | 78 +++++++
 rtl/vpu_timing_cntr_bank.sv | 48 ++++
 4 files changed

// File: rtl/vpu_timing_pkg.sv
// Shared types and defaults for the VPU timing counter bank.
// Contents:
//   load_mode_t          - selects overwrite or keep-longest loading
//   NUM_CH_DEFAULT       - default number of timing channels
//   CNTR_WIDTH_DEFAULT   - default counter width
package vpu_timing_pkg;

  localparam int unsigned NUM_CH_DEFAULT     = 4;
  localparam int unsigned CNTR_WIDTH_DEFAULT = 6;

  typedef enum logic {
    LOAD_OVERWRITE = 1'b0,
    LOAD_MAX       = 1'b1
  } load_mode_t;

endpackage : vpu_timing_pkg

// File: rtl/vpu_timing_cntr_bank_if.sv
// Interface between the address decoder / issue arbiter and the timing counter bank.
// Signals:
//   load_valid_i  per-channel load request
//   load_value_i  per-channel load values, channel k at [k*CNTR_WIDTH +: CNTR_WIDTH]
//   load_mode_i   overwrite or max, shared by all channels loading this cycle
//   stall_i       freeze decrements (loads still apply)
//   flush_i       force all counters to 0 next cycle
//   ready_o       registered counter == 0
//   ready_n_o     combinational next counter == 0
//   all_ready_o   AND of ready_o
//   expire_o      one-cycle pulse when a counter counted down to 0
//   cntr_o        current counter values, same packing as load_value_i
// Modports: master drives loads/controls, slave is the counter bank.
interface vpu_timing_cntr_bank_if
  import vpu_timing_pkg::*;
#(
  parameter int unsigned NUM_CH     = NUM_CH_DEFAULT,
  parameter int unsigned CNTR_WIDTH = CNTR_WIDTH_DEFAULT
);

  logic [NUM_CH-1:0]            load_valid_i;
  logic [NUM_CH*CNTR_WIDTH-1:0] load_value_i;
  load_mode_t                   load_mode_i;
  logic                         stall_i;
  logic                         flush_i;
  logic [NUM_CH-1:0]            ready_o;
  logic [NUM_CH-1:0]            ready_n_o;
  logic                         all_ready_o;
  logic [NUM_CH-1:0]            expire_o;
  logic [NUM_CH*CNTR_WIDTH-1:0] cntr_o;

  modport master (
    output load_valid_i,
    output load_value_i,
    output load_mode_i,
    output stall_i,
    output flush_i,
    input  ready_o,
    input  ready_n_o,
    input  all_ready_o,
    input  expire_o,
    input  cntr_o
  );

  modport slave (
    input  load_valid_i,
    input  load_value_i,
    input  load_mode_i,
    input  stall_i,
    input  flush_i,
    output ready_o,
    output ready_n_o,
    output all_ready_o,
    output expire_o,
    output cntr_o
  );

endinterface : vpu_timing_cntr_bank_if

// File: rtl/vpu_timing_cntr_ch.sv
// One saturating down-counter timing channel.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   load_valid_i   load request for this channel
//   load_value_i   value to load
//   load_mode_i    overwrite or keep-longest
//   stall_i        hold the counter this cycle (loads still apply)
//   flush_i        force the counter to 0 next cycle
//   ready_o        registered counter == 0
//   ready_n_o      next-state counter == 0 (one cycle early, combinational)
//   expire_o       registered pulse after counting down from 1 to 0
//   cntr_o         current counter value
module vpu_timing_cntr_ch
  import vpu_timing_pkg::*;
#(
  parameter int unsigned CNTR_WIDTH = CNTR_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid_i,
  input  logic [CNTR_WIDTH-1:0] load_value_i,
  input  load_mode_t            load_mode_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic                  ready_o,
  output logic                  ready_n_o,
  output logic                  expire_o,
  output logic [CNTR_WIDTH-1:0] cntr_o
);

  localparam logic [CNTR_WIDTH-1:0] CntrZero = '0;
  localparam logic [CNTR_WIDTH-1:0] CntrOne  = CntrZero + 1'b1;

  logic [CNTR_WIDTH-1:0] cntr_q, cntr_d;
  logic [CNTR_WIDTH-1:0] base;
  logic                  expire_q, expire_d;

  // Value the counter takes when nothing overrides it; saturates at 0.
  always_comb begin
    base = cntr_q;
    if (!stall_i && (cntr_q != CntrZero)) begin
      base = cntr_q - CntrOne;
    end
  end

  always_comb begin
    cntr_d   = base;
    expire_d = 1'b0;
    if (flush_i) begin
      cntr_d = CntrZero;
    end else if (load_valid_i) begin
      if (load_mode_i == LOAD_MAX) begin
        cntr_d = (load_value_i > base) ? load_value_i : base;
      end else begin
        cntr_d = load_value_i;
      end
    end else begin
      // Only a genuine decrement from 1 counts as expiry.
      expire_d = (cntr_q == CntrOne) && !stall_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cntr_q   <= CntrZero;
      expire_q <= 1'b0;
    end else begin
      cntr_q   <= cntr_d;
      expire_q <= expire_d;
    end
  end

  assign ready_o   = (cntr_q == CntrZero);
  assign ready_n_o = rst || (cntr_d == CntrZero);
  assign expire_o  = expire_q;
  assign cntr_o    = cntr_q;

endmodule : vpu_timing_cntr_ch

// File: rtl/vpu_timing_cntr_bank.sv
// Bank of NUM_CH independent saturating down-counters enforcing command timing for
// the VPU scheduler. Sits between the address decoder (loads) and the issue arbiter
// (ready flags).
// Ports:
//   clk   clock
//   rst   synchronous active-high reset
//   bus   vpu_timing_cntr_bank_if slave modport (loads, stall, flush, status outputs)
module vpu_timing_cntr_bank
  import vpu_timing_pkg::*;
#(
  parameter int unsigned NUM_CH     = NUM_CH_DEFAULT,
  parameter int unsigned CNTR_WIDTH = CNTR_WIDTH_DEFAULT
) (
  input logic                  clk,
  input logic                  rst,
  vpu_timing_cntr_bank_if.slave bus
);

  logic [NUM_CH-1:0]            ready;
  logic [NUM_CH-1:0]            ready_n;
  logic [NUM_CH-1:0]            expire;
  logic [NUM_CH*CNTR_WIDTH-1:0] cntr;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    vpu_timing_cntr_ch #(
      .CNTR_WIDTH (CNTR_WIDTH)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .load_valid_i (bus.load_valid_i[k]),
      .load_value_i (bus.load_value_i[k*CNTR_WIDTH +: CNTR_WIDTH]),
      .load_mode_i  (bus.load_mode_i),
      .stall_i      (bus.stall_i),
      .flush_i      (bus.flush_i),
      .ready_o      (ready[k]),
      .ready_n_o    (ready_n[k]),
      .expire_o     (expire[k]),
      .cntr_o       (cntr[k*CNTR_WIDTH +: CNTR_WIDTH])
    );
  end

  assign bus.ready_o     = ready;
  assign bus.ready_n_o   = ready_n;
  assign bus.all_ready_o = &ready;
  assign bus.expire_o    = expire;
  assign bus.cntr_o      = cntr;

endmodule : vpu_timing_cntr_bank
